pwm_seq_ctrl: RTL and testbench

- Sequencing and configuration controller for one PWM channel.
- Drives the channel's enable, period and duty-cycle inputs.
- Double-buffers host configuration and commits it only at period boundaries, so no glitched periods reach the channel.
- Provides soft-start: duty ramps from 0 to the target in fixed steps, one step per PWM period.
- Sits between the register file and the channel; one instance per channel.

---
 rtl/pwm_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: sequencing/configuration controller for one PWM channel.
// Double-buffers host config, commits on period boundaries, soft-start ramp.
// Optional build macro: PWM_RAMP_DOWN_EN (STOP ramps duty down before disable).
module pwm_seq_ctrl #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [W-1:0] cfg_period_i,
  input  logic [W-1:0] cfg_duty_i,
  input  logic [W-1:0] cfg_step_i,
  input  logic         start_i,
  input  logic         stop_i,
  output logic         ch_en_o,
  output logic [W-1:0] ch_period_o,
  output logic [W-1:0] ch_dc_o,
  output logic         boundary_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic         en_q, en_d;
  logic [W-1:0] per_q, per_d;
  logic [W-1:0] dc_q, dc_d;
  logic         bnd_q, bnd_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] step_q, step_d;
  logic         pend_q, pend_d;
  logic [W-1:0] stg_per_q, stg_per_d;
  logic [W-1:0] stg_duty_q, stg_duty_d;
  logic [W-1:0] stg_step_q, stg_step_d;

  logic         wrap;
  logic         accept;
  logic         commit;
  logic [W-1:0] eff_tgt;
  logic [W-1:0] eff_step;
  logic [W:0]   sum;
  logic         sum_reach;
  logic [W-1:0] ramp_val;
  logic [W-1:0] down_val;

  assign cfg_ready_o = !pend_q;
  assign ch_en_o     = en_q;
  assign ch_period_o = per_q;
  assign ch_dc_o     = dc_q;
  assign boundary_o  = bnd_q;
  assign state_o     = state_q;

  // Shared arithmetic: wrap detect, commit gating and ramp step values.
  // Values committed this cycle are used by ramp/start decisions made in the same cycle.
  always_comb begin
    wrap      = en_q && (cnt_q >= per_q);
    accept    = cfg_valid_i && !pend_q;
    commit    = pend_q && ((state_q == IDLE) || wrap);
    eff_tgt   = commit ? stg_duty_q : tgt_q;
    eff_step  = commit ? stg_step_q : step_q;
    sum       = {1'b0, dc_q} + {1'b0, eff_step};
    sum_reach = (sum >= {1'b0, eff_tgt});
    ramp_val  = sum_reach ? eff_tgt : sum[W-1:0];
    down_val  = (dc_q > eff_step) ? (dc_q - eff_step) : '0;
  end

  // Next-state: mirror counter, config handshake/commit and sequencing FSM.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    per_d      = per_q;
    dc_d       = dc_q;
    bnd_d      = 1'b0;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    pend_d     = pend_q;
    stg_per_d  = stg_per_q;
    stg_duty_d = stg_duty_q;
    stg_step_d = stg_step_q;

    if (en_q) begin
      if (wrap) begin
        cnt_d = '0;
        bnd_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end

    if (accept) begin
      stg_per_d  = cfg_period_i;
      stg_duty_d = cfg_duty_i;
      stg_step_d = cfg_step_i;
      pend_d     = 1'b1;
    end

    if (commit) begin
      per_d  = stg_per_q;
      tgt_d  = stg_duty_q;
      step_d = stg_step_q;
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          en_d = 1'b1;
          if (eff_step == '0) begin
            dc_d    = eff_tgt;
            state_d = RUN;
          end else begin
            dc_d    = '0;
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (stop_i) begin
          state_d = STOP;
        end else if (wrap) begin
          if ((eff_step == '0) || sum_reach) begin
            dc_d    = eff_tgt;
            state_d = RUN;
          end else begin
            dc_d = ramp_val;
          end
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = STOP;
        end else if (commit) begin
          if (stg_duty_q <= dc_q) begin
            dc_d = stg_duty_q;
          end else if (stg_step_q != '0) begin
            state_d = RAMP;
          end else begin
            dc_d = stg_duty_q;
          end
        end
      end
      STOP: begin
        if (wrap) begin
`ifdef PWM_RAMP_DOWN_EN
          if ((eff_step != '0) && (dc_q != '0)) begin
            dc_d = down_val;
          end else begin
            en_d    = 1'b0;
            dc_d    = '0;
            state_d = IDLE;
          end
`else
          en_d    = 1'b0;
          dc_d    = '0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      per_q      <= '0;
      dc_q       <= '0;
      bnd_q      <= 1'b0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      step_q     <= '0;
      pend_q     <= 1'b0;
      stg_per_q  <= '0;
      stg_duty_q <= '0;
      stg_step_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      per_q      <= per_d;
      dc_q       <= dc_d;
      bnd_q      <= bnd_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      pend_q     <= pend_d;
      stg_per_q  <= stg_per_d;
      stg_duty_q <= stg_duty_d;
      stg_step_q <= stg_step_d;
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard testbench for pwm_seq_ctrl: expected boundary snapshots are
// queued by the stimulus and checked by a monitor on each boundary pulse.
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [15:0] cfg_period_i = '0;
  logic [15:0] cfg_duty_i = '0;
  logic [15:0] cfg_step_i = '0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        ch_en_o;
  logic [15:0] ch_period_o;
  logic [15:0] ch_dc_o;
  logic        boundary_o;
  logic [1:0]  state_o;

  typedef struct {
    int en;
    int per;
    int dc;
    int st;
    int gap;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_bnd = -1;

  pwm_seq_ctrl #(.W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_period_i(cfg_period_i),
    .cfg_duty_i  (cfg_duty_i),
    .cfg_step_i  (cfg_step_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .ch_en_o     (ch_en_o),
    .ch_period_o (ch_period_o),
    .ch_dc_o     (ch_dc_o),
    .boundary_o  (boundary_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int en, input int per, input int dc, input int st, input int gap);
    exp_t e;
    e.en = en; e.per = per; e.dc = dc; e.st = st; e.gap = gap;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0) return;
      step(1);
    end
    chk({name, "_drain_timeout"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic offer_cfg(input int per, input int duty, input int stp);
    cfg_valid_i  = 1'b1;
    cfg_period_i = 16'(per);
    cfg_duty_i   = 16'(duty);
    cfg_step_i   = 16'(stp);
  endtask

  // Monitor: pops one expected snapshot per boundary pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (boundary_o) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("bnd_en", int'(ch_en_o), e.en);
          chk("bnd_period", int'(ch_period_o), e.per);
          chk("bnd_dc", int'(ch_dc_o), e.dc);
          chk("bnd_state", int'(state_o), e.st);
          if (e.gap > 0) chk("bnd_gap", cyc - last_bnd, e.gap);
        end
        last_bnd = cyc;
      end
    end
  end

  // Stimulus.
  initial begin
    step(3);
    rst_i = 1'b0;
    chk("rst_en", int'(ch_en_o), 0);
    chk("rst_period", int'(ch_period_o), 0);
    chk("rst_dc", int'(ch_dc_o), 0);
    chk("rst_bnd", int'(boundary_o), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_ready", int'(cfg_ready_o), 1);

    // RUN with period 9, duty 4, no ramp.
    offer_cfg(9, 4, 0);
    step(1);
    cfg_valid_i = 1'b0;
    chk("p1_ready_low", int'(cfg_ready_o), 0);
    step(1);
    chk("p1_period", int'(ch_period_o), 9);
    chk("p1_ready_high", int'(cfg_ready_o), 1);
    chk("p1_en_before", int'(ch_en_o), 0);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("p1_en", int'(ch_en_o), 1);
    chk("p1_dc", int'(ch_dc_o), 4);
    chk("p1_state", int'(state_o), 2);
    push(1, 9, 4, 2, 0);
    push(1, 9, 4, 2, 10);
    push(1, 9, 4, 2, 10);
    drain("p1");

    // Reconfigure while running: period 19, duty 2.
    push(1, 19, 2, 2, 10);
    push(1, 19, 2, 2, 20);
    offer_cfg(19, 2, 0);
    step(1);
    cfg_valid_i = 1'b0;
    chk("p3_ready_low", int'(cfg_ready_o), 0);
    step(7);
    chk("p3_period_hold", int'(ch_period_o), 9);
    chk("p3_dc_hold", int'(ch_dc_o), 4);
    chk("p3_ready_still_low", int'(cfg_ready_o), 0);
    step(1);
    chk("p3_period_new", int'(ch_period_o), 19);
    chk("p3_dc_new", int'(ch_dc_o), 2);
    chk("p3_ready_rise", int'(cfg_ready_o), 1);
    drain("p3");

    // Stop mid-period; disable lands on the wrap.
    push(0, 19, 0, 0, 20);
    step(5);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("stop_state", int'(state_o), 3);
    chk("stop_en_hold", int'(ch_en_o), 1);
    step(12);
    chk("stop_en_before_wrap", int'(ch_en_o), 1);
    step(1);
    chk("stop_en_off", int'(ch_en_o), 0);
    chk("stop_dc_zero", int'(ch_dc_o), 0);
    chk("stop_idle", int'(state_o), 0);
    drain("stop1");
    step(3);
    start_i = 1'b1;
    stop_i  = 1'b1;
    step(1);
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("startstop_state", int'(state_o), 0);
    step(5);
    chk("startstop_en", int'(ch_en_o), 0);

    // Soft-start ramp: period 9, target 10, step 3.
    offer_cfg(9, 10, 3);
    step(1);
    cfg_valid_i = 1'b0;
    chk("ramp_ready_low", int'(cfg_ready_o), 0);
    step(1);
    chk("ramp_period", int'(ch_period_o), 9);
    push(1, 9, 3, 1, 0);
    push(1, 9, 6, 1, 10);
    push(1, 9, 9, 1, 10);
    push(1, 9, 10, 2, 10);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("ramp_en", int'(ch_en_o), 1);
    chk("ramp_dc0", int'(ch_dc_o), 0);
    chk("ramp_state", int'(state_o), 1);
    drain("ramp");

    // Stop from RUN at duty 10, step 3.
`ifdef PWM_RAMP_DOWN_EN
    push(1, 9, 7, 3, 10);
    push(1, 9, 4, 3, 10);
    push(1, 9, 1, 3, 10);
    push(1, 9, 0, 3, 10);
    push(0, 9, 0, 0, 10);
`else
    push(0, 9, 0, 0, 10);
`endif
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("stop2_state", int'(state_o), 3);
    chk("stop2_dc_hold", int'(ch_dc_o), 10);
    drain("stop2");
    chk("stop2_idle", int'(state_o), 0);

    // Reset in the middle of a ramp; cfg and start during reset are ignored.
    push(1, 9, 3, 1, 0);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    drain("ramp2");
    step(3);
    chk("ramp2_mid_state", int'(state_o), 1);
    rst_i = 1'b1;
    offer_cfg(5, 5, 1);
    start_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    cfg_valid_i = 1'b0;
    start_i = 1'b0;
    chk("rst2_en", int'(ch_en_o), 0);
    chk("rst2_period", int'(ch_period_o), 0);
    chk("rst2_dc", int'(ch_dc_o), 0);
    chk("rst2_bnd", int'(boundary_o), 0);
    chk("rst2_state", int'(state_o), 0);
    chk("rst2_ready", int'(cfg_ready_o), 1);

    // Period 0 after reset: every cycle is a boundary.
    push(1, 0, 0, 2, 0);
    push(1, 0, 0, 2, 1);
    push(1, 0, 0, 2, 1);
    push(1, 0, 0, 2, 1);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("p0_en", int'(ch_en_o), 1);
    chk("p0_state", int'(state_o), 2);
    chk("p0_bnd_first", int'(boundary_o), 0);
    drain("p0");
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("p0_stop_state", int'(state_o), 3);
    step(1);
    chk("p0_idle", int'(state_o), 0);
    chk("p0_en_off", int'(ch_en_o), 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
